// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and helpers for the UART transmitter
//
// Purpose: state encoding, frame constants and a ceil-log2 helper used by
// the transmitter top, its FIFO and its handshake interface.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// rtl/uart_transmitter_if.sv - byte-write handshake between on-chip logic and the transmitter
//
// Purpose: groups the write strobe/data and the status outputs.
// Signals:
//   Tx_start - write strobe (master -> slave)
//   Tx_data  - byte captured with Tx_start (master -> slave)
//   Tx_full  - FIFO full, writes dropped while high (slave -> master)
//   Tx_busy  - frame on the line or bytes queued (slave -> master)
//   Tx_done  - one-cycle pulse at end of each stop bit (slave -> master)
interface uart_transmitter_if;
  import uart_pkg::*;

  logic                   Tx_start;
  logic [UART_DATA_W-1:0] Tx_data;
  logic                   Tx_full;
  logic                   Tx_busy;
  logic                   Tx_done;

  modport master (
    output Tx_start,
    output Tx_data,
    input  Tx_full,
    input  Tx_busy,
    input  Tx_done
  );

  modport slave (
    input  Tx_start,
    input  Tx_data,
    output Tx_full,
    output Tx_busy,
    output Tx_done
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO feeding the transmitter
//
// Purpose: Depth-entry show-ahead FIFO (dout always presents the head entry).
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   wr, din    - write strobe and data; ignored while full
//   rd, dout   - pop strobe and head data; ignored while empty
//   full/empty - occupancy flags, derived from the registered count
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [UART_DATA_W-1:0] din,
  output logic [UART_DATA_W-1:0] dout,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = clog2(Depth);
  localparam int CW = AW + 1;

  logic [UART_DATA_W-1:0] r_mem [Depth];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   w_do_wr;
  logic                   w_do_rd;

  assign full    = (r_count == CW'(Depth));
  assign empty   = (r_count == '0);
  assign w_do_wr = wr && !full;
  assign w_do_rd = rd && !empty;
  assign dout    = r_mem[r_rd_ptr];

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 UART transmitter with byte FIFO
//
// Purpose: buffers bytes written over tx_if and serialises them LSB-first
// on TxD, frames back to back while data is queued.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   tx_if      - write handshake and status (slave side)
//   TxD        - registered serial line, idle high
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int ClkFrequency = 100000000,
  parameter int Baud         = 9600,
  parameter int FifoDepth    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_transmitter_if.slave   tx_if,
  output logic                TxD
);

  localparam int DIV   = ClkFrequency / Baud;
  localparam int CNT_W = (clog2(DIV) < 1) ? 1 : clog2(DIV);

  uart_state_t            r_state;
  uart_state_t            w_state_nxt;
  logic [CNT_W-1:0]       r_baud_cnt;
  logic [CNT_W-1:0]       w_baud_cnt_nxt;
  logic [UART_DATA_W-1:0] r_shift;
  logic [UART_DATA_W-1:0] w_shift_nxt;
  logic [2:0]             r_bit_idx;
  logic [2:0]             w_bit_idx_nxt;
  logic                   r_txd;
  logic                   w_txd_nxt;
  logic                   r_done;
  logic                   w_done_nxt;

  logic                   w_pop;
  logic                   w_bit_end;
  logic [UART_DATA_W-1:0] w_fifo_dout;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;

  uart_tx_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (tx_if.Tx_start),
    .rd    (w_pop),
    .din   (tx_if.Tx_data),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  assign w_bit_end     = (r_baud_cnt == CNT_W'(DIV - 1));
  assign TxD           = r_txd;
  assign tx_if.Tx_full = w_fifo_full;
  assign tx_if.Tx_busy = (r_state != IDLE) || !w_fifo_empty;
  assign tx_if.Tx_done = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_txd      <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_txd      <= w_txd_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_baud_cnt_nxt = r_baud_cnt + CNT_W'(1);
    w_shift_nxt    = r_shift;
    w_bit_idx_nxt  = r_bit_idx;
    w_txd_nxt      = r_txd;
    w_done_nxt     = 1'b0;
    w_pop          = 1'b0;

    case (r_state)
      IDLE: begin
        w_txd_nxt      = 1'b1;
        w_baud_cnt_nxt = '0;
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_dout;
          w_txd_nxt   = 1'b0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_baud_cnt_nxt = '0;
          w_txd_nxt      = r_shift[0];
          w_bit_idx_nxt  = '0;
          w_state_nxt    = DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud_cnt_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_txd_nxt   = 1'b1;
            w_state_nxt = STOP;
          end else begin
            // The next bit is shift[1] before the shift lands.
            w_shift_nxt   = r_shift >> 1;
            w_txd_nxt     = r_shift[1];
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_baud_cnt_nxt = '0;
          w_done_nxt     = 1'b1;
          // Chain straight into the next start bit so frames have no gap.
          if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_dout;
            w_txd_nxt   = 1'b0;
            w_state_nxt = START;
          end else begin
            w_txd_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter
module tb_uart_transmitter;
  import uart_pkg::*;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DEPTH    = 4;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int FRAME    = UART_FRAME_BITS * DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic txd;

  uart_transmitter_if tx_if ();

  uart_transmitter #(
    .ClkFrequency (CLK_FREQ),
    .Baud         (BAUD),
    .FifoDepth    (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tx_if (tx_if),
    .TxD   (txd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending bytes, the byte on the line and cycles since its start edge.
  byte unsigned m_q[$];
  logic [7:0]   m_cur;
  bit           m_active;
  int           m_t;
  bit           m_done;

  int   cyc = 0;
  int   done_times[$];
  int   fall_times[$];
  logic prev_txd = 1'b1;

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
    else return 1'b1;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_active = 0;
    m_t      = 0;
    m_done   = 0;
    m_cur    = '0;
  endtask

  // What the coming rising edge does, given the inputs currently driven.
  task automatic model_edge();
    bit was_full;
    was_full = (m_q.size() == DEPTH);
    m_done   = 0;
    if (rst_n == 1'b0) begin
      model_clear();
      return;
    end
    if (m_active) begin
      if (m_t == FRAME - 1) begin
        m_done = 1;
        if (m_q.size() > 0) begin
          m_cur = m_q.pop_front();
          m_t   = 0;
        end else begin
          m_active = 0;
        end
      end else begin
        m_t++;
      end
    end else if (m_q.size() > 0) begin
      m_cur    = m_q.pop_front();
      m_active = 1;
      m_t      = 0;
    end
    if (tx_if.Tx_start && !was_full) m_q.push_back(tx_if.Tx_data);
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
    cyc++;
    check_eq("txd",  txd,           m_active ? frame_bit(m_cur, m_t / DIV) : 1'b1);
    check_eq("busy", tx_if.Tx_busy, m_active || (m_q.size() > 0));
    check_eq("full", tx_if.Tx_full, m_q.size() == DEPTH);
    check_eq("done", tx_if.Tx_done, m_done);
    if (tx_if.Tx_done === 1'b1) done_times.push_back(cyc);
    if (prev_txd === 1'b1 && txd === 1'b0) fall_times.push_back(cyc);
    prev_txd = txd;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    tx_if.Tx_start = 1'b1;
    tx_if.Tx_data  = b;
    tick();
    tx_if.Tx_start = 1'b0;
  endtask

  task automatic clear_log();
    done_times.delete();
    fall_times.delete();
  endtask

  // Asynchronous reset between clock edges; the line must go idle at once.
  task automatic reset_mid(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_eq({tag, "_txd"},  txd,           1'b1);
    check_eq({tag, "_busy"}, tx_if.Tx_busy, 1'b0);
    check_eq({tag, "_full"}, tx_if.Tx_full, 1'b0);
    model_clear();
    tx_if.Tx_start = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_expiry_edge();
    for (int i = 0; i < 2 * FRAME && !(m_active && m_t == FRAME - 1); i++) tick();
  endtask

  initial begin
    tx_if.Tx_start = 1'b0;
    tx_if.Tx_data  = '0;
    model_clear();

    // Reset idle
    repeat (3) tick();
    rst_n = 1'b1;
    clear_log();
    idle(50);
    check_eq("reset_no_done", done_times.size(), 0);

    // Single byte
    clear_log();
    send(8'hA5);
    idle(120);
    check_eq("single_done_cnt", done_times.size(), 1);
    check_eq("single_fall_to_done",
             (done_times.size() > 0 && fall_times.size() > 0) ? done_times[0] - fall_times[0] : -1,
             FRAME);
    check_eq("single_busy_end", tx_if.Tx_busy, 1'b0);

    // Back-to-back
    clear_log();
    send(8'h00);
    send(8'hFF);
    idle(2 * FRAME + 20);
    check_eq("b2b_done_cnt", done_times.size(), 2);
    check_eq("b2b_done_gap", (done_times.size() > 1) ? done_times[1] - done_times[0] : -1, FRAME);
    check_eq("b2b_fall_gap", (fall_times.size() > 1) ? fall_times[1] - fall_times[0] : -1, FRAME);

    // FIFO full: sixth byte dropped
    clear_log();
    for (int i = 1; i <= 6; i++) begin
      send(8'(i * 8'h11));
      if (i == 5) check_eq("fill_full_after_5", tx_if.Tx_full, 1'b1);
    end
    idle(5 * FRAME + 20);
    check_eq("fill_done_cnt", done_times.size(), 5);

    // Reset during bit 3 of 0x0F with two bytes queued
    clear_log();
    send(8'h0F);
    send(8'hA1);
    send(8'hB2);
    idle(43);
    reset_mid("rst_bit3");
    idle(3 * FRAME);
    check_eq("rst_bit3_no_done", done_times.size(), 0);

    // Reset during a start bit (line low)
    clear_log();
    send(8'($urandom));
    idle(5);
    reset_mid("rst_start");
    idle(FRAME + 10);
    check_eq("rst_start_no_done", done_times.size(), 0);

    // Write on the pop edge: dropped while full, accepted when not full
    clear_log();
    send(8'h5A);
    for (int i = 0; i < DEPTH; i++) send(8'($urandom));
    check_eq("popedge_prefull", tx_if.Tx_full, 1'b1);
    wait_expiry_edge();
    send(8'hC3);
    check_eq("popedge_drop_full", tx_if.Tx_full, 1'b0);
    wait_expiry_edge();
    send(8'hD4);
    check_eq("popedge_accept_full", tx_if.Tx_full, 1'b0);
    idle(5 * FRAME);
    check_eq("popedge_done_cnt", done_times.size(), 6);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      tx_if.Tx_start = ($urandom_range(0, 99) < 6);
      tx_if.Tx_data  = 8'($urandom);
      tick();
    end
    tx_if.Tx_start = 1'b0;
    idle((DEPTH + 1) * FRAME + 10);
    check_eq("random_drained_busy", tx_if.Tx_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

8N1 UART transmitter with a small byte FIFO, the transmit-side counterpart to the team's UART receiver. The block accepts bytes from on-chip logic over a strobe/full handshake and buffers them. It serialises them LSB-first on `TxD` at a fixed baud rate derived from `clk`. Frames are sent back to back with no idle gap while the FIFO holds data.

## Interface
- `ClkFrequency`, 100000000: clock frequency in Hz.
- `Baud`, 9600: bit rate. `DIV = ClkFrequency/Baud` is integer-truncated and must be ≥ 2.
- `FifoDepth`, 4: byte FIFO depth. Must be a power of 2, ≥ 2.

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `Tx_start`  in  1: write strobe; one byte is accepted per cycle when high and `Tx_full` is low.
- `Tx_data`  in  8: byte captured with `Tx_start`.
- `Tx_full`  out  1: FIFO full; writes are dropped while high.
- `Tx_busy`  out  1: high while a frame is on the line or the FIFO is non-empty.
- `Tx_done`  out  1: one-cycle pulse at the end of each stop bit.
- `TxD`  out  1: serial line, registered, idle high.

## Operation
- Reset values: `TxD`=1, `Tx_full`=0, `Tx_busy`=0, `Tx_done`=0, FIFO empty, state IDLE, baud counter 0.
- Reset asserted mid-frame: `TxD` returns to 1 immediately (asynchronously). All queued bytes are discarded.
- FIFO behaviour:
  - Write when `Tx_start && !Tx_full`.
  - A write while full is silently dropped; no state changes.
  - Simultaneous write and pop: both take effect and the count is unchanged.
  - There is no bypass: a byte written into an empty FIFO is popped no earlier than the next cycle.
  - Pointers are `log2(FifoDepth)` bits and wrap naturally. Count is `log2(FifoDepth)+1` bits.
- State machine:
  - IDLE: `TxD`=1. If the FIFO is non-empty, pop into an 8-bit shift register, set `TxD`←0, clear the baud counter, go to START.
  - START: hold for DIV cycles, then go to DATA with `TxD`←shift[0] and bit index 0.
  - DATA: each bit lasts DIV cycles. On expiry, shift right and increment the index. After bit 7 expires, set `TxD`←1 and go to STOP.
  - STOP: hold 1 for DIV cycles. On expiry, pulse `Tx_done`. If the FIFO is non-empty, pop and enter START directly (`TxD`←0 on the same edge); otherwise go to IDLE.
- Baud counter: counts 0..DIV-1 and restarts at every bit boundary. It is cleared on entry to START, so every bit is exactly DIV cycles with no phase carry-over between frames.
- `Tx_busy` = (state ≠ IDLE) | FIFO non-empty.

## Timing
- A write sampled at edge N enters the FIFO at N. IDLE pops at N+1, and `TxD` falls after edge N+1.
- Frame length: exactly 10·DIV cycles.
- Bit k (k = 0..7) is driven from (1+k)·DIV to (2+k)·DIV cycles after the start edge.
- Back-to-back frames: the next start bit follows the stop bit with zero idle cycles.
- `Tx_done` is high for exactly the one cycle after the stop-bit expiry edge.
- `Tx_full` is registered and reflects the count after the current edge's write/pop.

## Structure
- Shared package `uart_pkg`:
  - state encoding: IDLE, START, DATA, STOP (2 bits);
  - `UART_DATA_W=8`;
  - `UART_FRAME_BITS=10`;
  - a `clog2` helper function.
- One sub-module, `uart_tx_fifo`: a synchronous FIFO with parameter `Depth`, ports wr/rd/din/dout/full/empty, and async active-low reset.
- The baud divider, shift register and FSM live in the top module.

## Test plan
Benches use `ClkFrequency`=1000 and `Baud`=100, so DIV=10.
- **Reset idle:** hold `rst_n`=0 for 3 cycles, then release → `TxD`=1, `Tx_busy`=0, `Tx_full`=0, and no `Tx_done` for 50 cycles.
- **Single byte:** write 0xA5 → `TxD` reads 0,1,0,1,0,0,1,0,1,1 with each level held 10 cycles. `Tx_done` pulses once, 100 cycles after the falling edge. `Tx_busy` then drops.
- **Back-to-back:** write 0x00 then 0xFF on consecutive cycles → two 100-cycle frames with no idle gap and two `Tx_done` pulses 100 cycles apart.
- **FIFO full:** write 0x11, 0x22, 0x33, 0x44, 0x55, 0x66 on consecutive cycles (depth 4).
  - 0x11 is popped at once.
  - `Tx_full` rises after the fifth write, so 0x66 is dropped.
  - The line carries exactly 0x11–0x55.
- **Reset mid-frame:** assert `rst_n`=0 during bit 3 of 0x0F with two bytes queued → `TxD`=1 immediately and `Tx_busy`=0 after release. No further frames are sent.
- **Write on pop edge:** with the FIFO full, write on the cycle a STOP expiry pops → the write is accepted only if `Tx_full` was low when sampled; otherwise it is dropped. Check against the count.
